dpram_stream_reader: RTL and testbench

- Downstream consumer of the DPRAM read-only port (port 2: 128 x 18, registered read).
- On a start pulse it reads a block of words beginning at a base address, with circular wrap.
- It streams the words out on a valid/ready interface with backpressure, full 1-word/cycle throughput, and a last-word flag.
- It feeds the next processing stage (filter/output path) from the frame buffer that port 1 fills.

---
 rtl/psd_dpram_pkg.sv | 17 +
 rtl/rd_skid_fifo.sv | 53 +++++
 rtl/dpram_stream_reader.sv | 117 +++++++++++
 tb/tb_dpram_stream_reader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/psd_dpram_pkg.sv
// Shared constants and reader state encoding for the DPRAM port-2 stream reader.
// The skid FIFO depth follows from the RAM read latency.
package psd_dpram_pkg;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 18;
    localparam int LEN_W      = 8;
    localparam int RD_LAT     = 1;
    localparam int FIFO_DEPTH = 1 + RD_LAT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry synchronous FIFO between the registered RAM read and the output stream.
// The head entry drives the stream directly, so it stays stable until it is popped.
module rd_skid_fifo #(
    parameter int W = 19
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_valid,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_push;

    assign w_pop  = i_pop & (r_count != 2'd0);
    assign w_push = i_push & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/dpram_stream_reader.sv
// Reads a circular block from DPRAM port 2 and streams it out with valid/ready backpressure.
//   state    | meaning
//   ST_IDLE  | waiting for start; length=0 just pulses done
//   ST_READ  | issuing one address per cycle while FIFO credit allows
//   ST_DRAIN | all reads issued; waiting for the last word to be accepted
module dpram_stream_reader #(
    parameter int ADDR_W = psd_dpram_pkg::ADDR_W,
    parameter int DATA_W = psd_dpram_pkg::DATA_W,
    parameter int LEN_W  = psd_dpram_pkg::LEN_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] dataout2,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    import psd_dpram_pkg::*;

    rd_state_t         r_state;
    rd_state_t         w_next_state;
    logic [ADDR_W-1:0] r_addr2;
    logic [LEN_W-1:0]  r_issue_cnt;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_wr_idx;
    logic              r_inflight;
    logic              r_done;

    logic              w_fifo_valid;
    logic [1:0]        w_fifo_count;
    logic [DATA_W:0]   w_fifo_din;
    logic [DATA_W:0]   w_fifo_dout;
    logic              w_pop;
    logic [2:0]        w_credit;
    logic              w_issue;
    logic              w_drain_done;
    logic              w_start_ok;
    logic              w_start_zero;

    assign w_pop        = w_fifo_valid & m_ready;
    assign w_credit     = {1'b0, w_fifo_count} + {2'b00, r_inflight};
    // A pop this cycle frees a slot in time for the word issued now.
    assign w_issue      = (r_state == ST_READ) &&
                          ((w_credit < 3'(FIFO_DEPTH)) || ((w_credit == 3'(FIFO_DEPTH)) && w_pop));
    assign w_drain_done = !r_inflight &&
                          ((w_fifo_count == 2'd0) || ((w_fifo_count == 2'd1) && w_pop));
    assign w_start_ok   = (r_state == ST_IDLE) && start && (length != '0);
    assign w_start_zero = (r_state == ST_IDLE) && start && (length == '0);
    assign w_fifo_din   = {(r_wr_idx == r_len - 1'b1), dataout2};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_ok) w_next_state = ST_READ;
            ST_READ:  if (w_issue && (r_issue_cnt == {{(LEN_W-1){1'b0}}, 1'b1})) w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_drain_done) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_addr2     <= '0;
            r_issue_cnt <= '0;
            r_len       <= '0;
            r_wr_idx    <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_inflight <= w_issue;
            r_done     <= w_start_zero || ((r_state == ST_DRAIN) && w_drain_done);
            if (w_start_ok) begin
                r_addr2     <= base_addr;
                r_issue_cnt <= length;
                r_len       <= length;
                r_wr_idx    <= '0;
            end else if (w_issue) begin
                r_addr2     <= r_addr2 + 1'b1;
                r_issue_cnt <= r_issue_cnt - 1'b1;
            end
            if (r_inflight) begin
                r_wr_idx <= r_wr_idx + 1'b1;
            end
        end
    end

    rd_skid_fifo #(
        .W(DATA_W + 1)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst_n (resetn),
        .i_push  (r_inflight),
        .i_din   (w_fifo_din),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign addr2   = r_addr2;
    assign m_data  = w_fifo_dout[DATA_W-1:0];
    assign m_valid = w_fifo_valid;
    assign m_last  = w_fifo_valid & w_fifo_dout[DATA_W];

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Table-driven bench for dpram_stream_reader with a registered-read RAM model
// and a scoreboard queue of expected {last, data} beats.
module tb_dpram_stream_reader;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [6:0]  base_addr;
    logic [7:0]  length;
    logic        busy;
    logic        done;
    logic [6:0]  addr2;
    logic [17:0] dataout2;
    logic [17:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    logic [17:0] mem [128];
    logic [18:0] sb [$];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int base;
        int len;
        int mode;      // 0: ready high, 1: fixed toggle pattern, 2: random
        int restart;   // pulse start again while busy
        int exp_busy;  // expected busy cycles, -1 when ready-dependent
    } vec_t;

    vec_t vecs [8];

    dpram_stream_reader dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .addr2     (addr2),
        .dataout2  (dataout2),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) dataout2 <= mem[addr2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          beats;
        int          busy_cnt;
        int          first_valid;
        int          done_k;
        int          last_acc;
        int          max_cnt;
        int          spurious;
        bit          seen;
        logic        prev_stall;
        logic [17:0] prev_data;
        logic [6:0]  a;
        logic [6:0]  prev_addr;
        logic [5:0]  pat;
        logic [18:0] exp;
        beats = 0; busy_cnt = 0; first_valid = -1; done_k = -1; last_acc = -1;
        max_cnt = 0; spurious = 0; seen = 0; prev_stall = 0; prev_data = '0;
        pat = 6'b101001;
        prev_addr = addr2;
        for (int i = 0; i < v.len; i++) begin
            a = 7'(v.base + i);
            sb.push_back({(i == v.len - 1), mem[a]});
        end
        start = 1'b1; base_addr = 7'(v.base); length = 8'(v.len);
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 0; k < 4 * v.len + 50; k++) begin
            case (v.mode)
                0:       m_ready = 1'b1;
                1:       m_ready = pat[k % 6];
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (v.restart != 0 && k == 3) begin
                start = 1'b1; base_addr = 7'd50; length = 8'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            if (k == 0) chk($sformatf("v%0d_addr2_first", idx), addr2, (v.len > 0) ? 7'(v.base) : prev_addr);
            if (int'(dut.u_fifo.o_count) > max_cnt) max_cnt = int'(dut.u_fifo.o_count);
            if (busy) busy_cnt++;
            if (prev_stall) chk($sformatf("v%0d_stall_hold", idx), {m_valid, m_data}, {1'b1, prev_data});
            if (m_valid && first_valid < 0) first_valid = k;
            if (m_valid && m_ready) begin
                beats++;
                last_acc = k;
                if (sb.size() == 0) begin
                    chk($sformatf("v%0d_extra_beat", idx), {m_last, m_data}, 19'h7ffff);
                end else begin
                    exp = sb.pop_front();
                    chk($sformatf("v%0d_beat%0d", idx, beats - 1), {m_last, m_data}, exp);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (done) begin
                done_k = k;
                seen = 1;
            end
            @(posedge clock); #1;
            if (seen) break;
        end
        start = 1'b0;
        chk($sformatf("v%0d_done_seen", idx), seen, 1'b1);
        chk($sformatf("v%0d_beats", idx), beats, v.len);
        chk($sformatf("v%0d_sb_left", idx), sb.size(), 0);
        chk($sformatf("v%0d_first_valid", idx), first_valid, (v.len > 0) ? 2 : -1);
        chk($sformatf("v%0d_done_k", idx), done_k, (v.len > 0) ? last_acc + 1 : 0);
        if (v.exp_busy >= 0) chk($sformatf("v%0d_busy_cycles", idx), busy_cnt, v.exp_busy);
        chk($sformatf("v%0d_fifo_le2", idx), (max_cnt <= 2), 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (done || busy || m_valid) spurious++;
            @(posedge clock); #1;
        end
        chk($sformatf("v%0d_quiet_after", idx), spurious, 0);
        sb.delete();
    endtask

    initial begin
        bit got_valid;
        int quiet_bad;
        for (int i = 0; i < 128; i++) mem[i] = 18'(i + 100);
        vecs[0] = '{base: 5,   len: 4,   mode: 0, restart: 0, exp_busy: 6};
        vecs[1] = '{base: 126, len: 4,   mode: 0, restart: 0, exp_busy: 6};
        vecs[2] = '{base: 0,   len: 8,   mode: 1, restart: 0, exp_busy: -1};
        vecs[3] = '{base: 20,  len: 0,   mode: 0, restart: 0, exp_busy: 0};
        vecs[4] = '{base: 40,  len: 3,   mode: 0, restart: 1, exp_busy: 5};
        vecs[5] = '{base: 0,   len: 128, mode: 0, restart: 0, exp_busy: 130};
        vecs[6] = '{base: 100, len: 50,  mode: 2, restart: 0, exp_busy: -1};
        vecs[7] = '{base: 127, len: 1,   mode: 0, restart: 0, exp_busy: 3};

        resetn = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_outputs", {busy, done, m_valid, m_last, m_data, addr2}, '0);
        resetn = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset in the middle of a stalled block.
        m_ready = 1'b0; start = 1'b1; base_addr = 7'd10; length = 8'd8;
        @(posedge clock); #1;
        start = 1'b0;
        got_valid = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (m_valid) begin
                got_valid = 1;
                break;
            end
        end
        chk("midreset_valid_before", {got_valid, busy}, 2'b11);
        #2 resetn = 1'b0;
        #1;
        chk("midreset_async_outputs", {busy, done, m_valid, m_last, m_data, addr2}, '0);
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        m_ready = 1'b1;
        quiet_bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (done || busy || m_valid) quiet_bad++;
        end
        chk("midreset_no_done", quiet_bad, 0);
        @(posedge clock); #1;
        run_vec(vecs[0], 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
